// File: rtl/demod_out_decimator.sv
// Boxcar-average / decimate-by-2^DEC_LOG2 of the demodulator output, mode-tagged, buffered in an FWFT FIFO.
// Build option DEC_ROUND_EN: round half toward +inf before the decimating shift (default: floor).
module demod_out_decimator #(
    parameter int DATA_W     = 16,
    parameter int DEC_LOG2   = 4,
    parameter int FIFO_AW    = 3,
    parameter int SETTLE_CYC = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] d_in,
    input  logic              in_en,
    input  logic [1:0]        mode_select,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FIFO_AW:0]  fifo_level,
    output logic              overflow,
    input  logic              ovf_clr
);
    localparam int ACC_W = DATA_W + 1 + DEC_LOG2;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int SC_W  = $clog2(SETTLE_CYC + 1);

    typedef enum logic [1:0] {IDLE, SETTLE, ACCUM} state_t;

    state_t                   state;
    logic [1:0]               mode_q;
    logic                     mode_chg;
    logic signed [DATA_W:0]   smp;
    logic signed [ACC_W-1:0]  acc, acc_next, acc_rnd;
    logic [DEC_LOG2-1:0]      cnt;
    logic [SC_W-1:0]          settle_cnt;
    logic [DATA_W-1:0]        res_word, res_data;
    logic [1:0]               res_mode;
    logic                     res_vld;

    assign mode_chg = (mode_select != mode_q);

    always_comb begin
        smp = '0;
        case (mode_q)
            2'b00:   smp = {{(DATA_W-7){1'b0}}, d_in[7:0]};
            2'b01:   smp = {{(DATA_W-7){d_in[7]}}, d_in[7:0]};
            default: smp = {d_in[DATA_W-1], d_in};
        endcase
    end

    assign acc_next = acc + $signed({{DEC_LOG2{smp[DATA_W]}}, smp});

`ifdef DEC_ROUND_EN
    localparam logic [ACC_W-1:0] RND = ACC_W'(1) << (DEC_LOG2 - 1);
    assign acc_rnd = acc_next + $signed(RND);
`else
    assign acc_rnd = acc_next;
`endif

    assign res_word = DATA_W'(acc_rnd >>> DEC_LOG2);

    // Any mode change (checked first) drops the current sample and any partial sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= 2'b11;
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            settle_cnt <= '0;
            res_vld    <= 1'b0;
            res_data   <= '0;
            res_mode   <= '0;
        end else begin
            mode_q  <= mode_select;
            res_vld <= 1'b0;
            if (mode_chg) begin
                acc        <= '0;
                cnt        <= '0;
                settle_cnt <= '0;
                state      <= (mode_select == 2'b11) ? IDLE : SETTLE;
            end else begin
                case (state)
                    IDLE: ;
                    SETTLE: begin
                        acc <= '0;
                        cnt <= '0;
                        if (in_en) begin
                            if (settle_cnt == SC_W'(SETTLE_CYC - 1)) begin
                                settle_cnt <= '0;
                                state      <= ACCUM;
                            end else begin
                                settle_cnt <= settle_cnt + 1'b1;
                            end
                        end
                    end
                    ACCUM: begin
                        if (in_en) begin
                            if (cnt == '1) begin
                                res_vld  <= 1'b1;
                                res_data <= res_word;
                                res_mode <= mode_q;
                                acc      <= '0;
                                cnt      <= '0;
                            end else begin
                                acc <= acc_next;
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    logic [DATA_W-1:0]  mem_d [DEPTH];
    logic [1:0]         mem_m [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr, rd_nxt;
    logic [FIFO_AW:0]   level_nxt;
    logic               full, pop, wr_ok;

    assign full   = (fifo_level == (FIFO_AW+1)'(DEPTH));
    assign pop    = out_valid && out_ready;
    assign wr_ok  = res_vld && (!full || pop);
    assign rd_nxt = rd_ptr + 1'b1;

    always_comb begin
        level_nxt = fifo_level;
        case ({wr_ok, pop})
            2'b10:   level_nxt = fifo_level + 1'b1;
            2'b01:   level_nxt = fifo_level - 1'b1;
            default: level_nxt = fifo_level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_d[wr_ptr] <= res_data;
            mem_m[wr_ptr] <= res_mode;
        end
    end

    // Head register: refilled from the next slot on pop, or straight from the write when the FIFO drains to it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_mode   <= '0;
            overflow   <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_nxt;
            fifo_level <= level_nxt;
            out_valid  <= (level_nxt != '0);
            if (pop) begin
                if (fifo_level > (FIFO_AW+1)'(1)) begin
                    out_data <= mem_d[rd_nxt];
                    out_mode <= mem_m[rd_nxt];
                end else if (wr_ok) begin
                    out_data <= res_data;
                    out_mode <= res_mode;
                end
            end else if (!out_valid && wr_ok) begin
                out_data <= res_data;
                out_mode <= res_mode;
            end
            if (res_vld && full && !pop)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_demod_out_decimator.sv
// Directed bench for demod_out_decimator: settle/decimate timing, mode extension, FIFO full/drain, mode switch, reset.
module tb_demod_out_decimator;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] d_in;
    logic        in_en;
    logic [1:0]  mode_select;
    logic [15:0] out_data;
    logic [1:0]  out_mode;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  fifo_level;
    logic        overflow;
    logic        ovf_clr;

    int n_checks = 0;
    int n_errors = 0;
    int ecnt = 0;

    demod_out_decimator dut (
        .clk(clk), .rst_n(rst_n), .d_in(d_in), .in_en(in_en), .mode_select(mode_select),
        .out_data(out_data), .out_mode(out_mode), .out_valid(out_valid), .out_ready(out_ready),
        .fifo_level(fifo_level), .overflow(overflow), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        ecnt++;
    endtask

    function automatic logic [15:0] fm_word(input int j);
        return 16'h0100 + 16'(j) * 16'h0010;
    endfunction

    // FM stream whose decimation window j holds the constant fm_word(j)
    task automatic fm_ramp(input int n);
        repeat (n) begin
            d_in = (ecnt >= 65) ? fm_word((ecnt - 65) / 16) : 16'h0000;
            step();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; mode_select = 2'b11; in_en = 1'b0; d_in = '0;
        out_ready = 1'b0; ovf_clr = 1'b0;
        #3;
        step(); step();
        rst_n = 1'b1;
        ecnt = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({out_valid, out_data, out_mode, fifo_level, overflow} !== 24'h0) begin
            n_errors++;
            $display("FAIL reset_outputs: got v=%b d=%h m=%b l=%0d o=%b, want all zero",
                     out_valid, out_data, out_mode, fifo_level, overflow);
        end
    endtask

    task automatic test_fm();
        do_reset();
        mode_select = 2'b10; in_en = 1'b1;
        fm_ramp(81);
        n_checks++;
        if (out_valid !== 1'b0) begin n_errors++; $display("FAIL fm_early_valid: got %b want 0", out_valid); end
        fm_ramp(1);
        n_checks++;
        if (out_valid !== 1'b1) begin n_errors++; $display("FAIL fm_valid: got %b want 1", out_valid); end
        n_checks++;
        if (out_data !== 16'h0100) begin n_errors++; $display("FAIL fm_data: got %h want 0100", out_data); end
        n_checks++;
        if (out_mode !== 2'b10) begin n_errors++; $display("FAIL fm_mode: got %b want 10", out_mode); end
        n_checks++;
        if (fifo_level !== 4'd1) begin n_errors++; $display("FAIL fm_level: got %0d want 1", fifo_level); end
    endtask

    task automatic test_bpsk();
        logic [15:0] exp_d;
`ifdef DEC_ROUND_EN
        exp_d = 16'h0000;
`else
        exp_d = 16'hFFFF;
`endif
        do_reset();
        mode_select = 2'b01; in_en = 1'b1;
        repeat (82) begin
            d_in = ecnt[0] ? 16'h127F : 16'hA580;
            step();
        end
        n_checks++;
        if (out_valid !== 1'b1) begin n_errors++; $display("FAIL bpsk_valid: got %b want 1", out_valid); end
        n_checks++;
        if (out_data !== exp_d) begin n_errors++; $display("FAIL bpsk_data: got %h want %h", out_data, exp_d); end
        n_checks++;
        if (out_mode !== 2'b01) begin n_errors++; $display("FAIL bpsk_mode: got %b want 01", out_mode); end
    endtask

    task automatic test_am();
        do_reset();
        mode_select = 2'b00; in_en = 1'b1; d_in = 16'hABFF;
        repeat (82) step();
        n_checks++;
        if (out_valid !== 1'b1) begin n_errors++; $display("FAIL am_valid: got %b want 1", out_valid); end
        n_checks++;
        if (out_data !== 16'h00FF) begin n_errors++; $display("FAIL am_data: got %h want 00ff", out_data); end
        n_checks++;
        if (out_mode !== 2'b00) begin n_errors++; $display("FAIL am_mode: got %b want 00", out_mode); end
    endtask

    task automatic test_overflow();
        do_reset();
        mode_select = 2'b10; in_en = 1'b1;
        fm_ramp(209);
        n_checks++;
        if (fifo_level !== 4'd8) begin n_errors++; $display("FAIL ovf_fill_level: got %0d want 8", fifo_level); end
        n_checks++;
        if (overflow !== 1'b0) begin n_errors++; $display("FAIL ovf_early: got %b want 0", overflow); end
        ovf_clr = 1'b1;
        fm_ramp(1);
        ovf_clr = 1'b0;
        n_checks++;
        if (overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_set_wins: got %b want 1", overflow); end
        n_checks++;
        if (fifo_level !== 4'd8) begin n_errors++; $display("FAIL ovf_level: got %0d want 8", fifo_level); end
        in_en = 1'b0; out_ready = 1'b1; ovf_clr = 1'b1;
        for (int j = 0; j < 8; j++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== fm_word(j) || out_mode !== 2'b10) begin
                n_errors++;
                $display("FAIL drain_word%0d: got v=%b d=%h m=%b want v=1 d=%h m=10",
                         j, out_valid, out_data, out_mode, fm_word(j));
            end
            step();
            ovf_clr = 1'b0;
            if (j == 0) begin
                n_checks++;
                if (overflow !== 1'b0) begin n_errors++; $display("FAIL ovf_clear: got %b want 0", overflow); end
            end
        end
        n_checks++;
        if (out_valid !== 1'b0 || fifo_level !== 4'd0) begin
            n_errors++; $display("FAIL drain_empty: got v=%b l=%0d want v=0 l=0", out_valid, fifo_level);
        end
        step();
        n_checks++;
        if (out_data !== fm_word(7) || fifo_level !== 4'd0) begin
            n_errors++; $display("FAIL empty_hold: got d=%h l=%0d want d=%h l=0", out_data, fifo_level, fm_word(7));
        end
        out_ready = 1'b0;
    endtask

    task automatic test_full_popwrite();
        do_reset();
        mode_select = 2'b10; in_en = 1'b1;
        fm_ramp(209);
        out_ready = 1'b1;
        fm_ramp(1);
        out_ready = 1'b0;
        n_checks++;
        if (fifo_level !== 4'd8 || overflow !== 1'b0) begin
            n_errors++; $display("FAIL full_popwrite: got l=%0d o=%b want l=8 o=0", fifo_level, overflow);
        end
        n_checks++;
        if (out_data !== fm_word(1)) begin n_errors++; $display("FAIL full_popwrite_head: got %h want %h", out_data, fm_word(1)); end
    endtask

    task automatic test_mode_switch();
        do_reset();
        mode_select = 2'b10; in_en = 1'b1;
        fm_ramp(91);
        n_checks++;
        if (fifo_level !== 4'd1) begin n_errors++; $display("FAIL sw_pre_level: got %0d want 1", fifo_level); end
        mode_select = 2'b01; d_in = 16'h0005;
        repeat (81) step();
        n_checks++;
        if (fifo_level !== 4'd1 || out_mode !== 2'b10 || out_data !== 16'h0100) begin
            n_errors++; $display("FAIL sw_no_partial: got l=%0d m=%b d=%h want l=1 m=10 d=0100", fifo_level, out_mode, out_data);
        end
        step();
        n_checks++;
        if (fifo_level !== 4'd2) begin n_errors++; $display("FAIL sw_new_word: got %0d want 2", fifo_level); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_checks++;
        if (out_mode !== 2'b01 || out_data !== 16'h0005 || fifo_level !== 4'd1) begin
            n_errors++; $display("FAIL sw_second: got m=%b d=%h l=%0d want m=01 d=0005 l=1", out_mode, out_data, fifo_level);
        end
    endtask

    task automatic test_idle_reset();
        do_reset();
        mode_select = 2'b11; in_en = 1'b1; d_in = 16'h1234;
        repeat (200) step();
        n_checks++;
        if (out_valid !== 1'b0 || fifo_level !== 4'd0) begin
            n_errors++; $display("FAIL idle_no_output: got v=%b l=%0d want 0 0", out_valid, fifo_level);
        end
        mode_select = 2'b10;
        fm_ramp(118);
        n_checks++;
        if (fifo_level !== 4'd3) begin n_errors++; $display("FAIL pre_rst_level: got %0d want 3", fifo_level); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || fifo_level !== 4'd0 || overflow !== 1'b0 || out_data !== 16'h0) begin
            n_errors++; $display("FAIL async_reset: got v=%b l=%0d o=%b d=%h want all 0", out_valid, fifo_level, overflow, out_data);
        end
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_fm();
        test_bpsk();
        test_am();
        test_overflow();
        test_full_popwrite();
        test_mode_switch();
        test_idle_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
